// File: rtl/motor_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : motor_cmd_sequencer_if                                           |
// | Brief   : Command/status bundle between a motor controller and sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface motor_cmd_sequencer_if;
    logic               enable;
    logic               estop;
    logic signed [15:0] cmd_in;
    logic               cmd_valid;
    logic signed [15:0] cmd_out;
    logic [2:0]         state;
    logic               at_target;
    logic               fault;

    modport master (
        output enable, estop, cmd_in, cmd_valid,
        input  cmd_out, state, at_target, fault
    );

    modport slave (
        input  enable, estop, cmd_in, cmd_valid,
        output cmd_out, state, at_target, fault
    );
endinterface
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : motor_cmd_sequencer                                              |
// | Brief   : Slew-limited motor command with braked direction reversal,       |
// |           dead time and latched emergency-stop fault.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module motor_cmd_sequencer #(
    parameter int RAMP_STEP   = 16,
    parameter int TICK_DIV    = 256,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    motor_cmd_sequencer_if.slave  bus
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] c_PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DEAD_W-1:0]  c_DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [16:0]        c_STEP17     = 17'(RAMP_STEP);
    localparam logic signed [15:0] c_STEP16     = 16'(RAMP_STEP);
    localparam logic signed [15:0] c_CMD_NEG_LIM = 16'sh8001;
    localparam logic signed [15:0] c_CMD_NEG_BAD = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_BRAKE = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic signed [15:0] cmd_out_q,   cmd_out_d;
    logic signed [15:0] target_q,    target_d;
    logic [PRESC_W-1:0] presc_q,     presc_d;
    logic [DEAD_W-1:0]  dead_q,      dead_d;
    logic               at_target_q, at_target_d;
    logic               fault_q,     fault_d;

    logic               w_tick;
    logic               w_rev;
    logic signed [15:0] w_goal;
    logic signed [15:0] w_cmd_in_clamped;
    logic signed [16:0] w_diff;
    logic [16:0]        w_abs_diff;
    logic signed [15:0] w_step_val;

    assign w_tick = (presc_q == c_PRESC_LAST);

    // Zero counts as neither sign, so ramping out of zero never looks like a reversal.
    assign w_rev = (!cmd_out_q[15] && (cmd_out_q != '0) && target_q[15]) ||
                   (cmd_out_q[15] && !target_q[15] && (target_q != '0));

    assign w_cmd_in_clamped = (bus.cmd_in == c_CMD_NEG_BAD) ? c_CMD_NEG_LIM : bus.cmd_in;

    always_comb begin
        w_goal     = (state_q == ST_RUN) ? target_q : '0;
        w_diff     = {w_goal[15], w_goal} - {cmd_out_q[15], cmd_out_q};
        w_abs_diff = w_diff[16] ? $unsigned(-w_diff) : $unsigned(w_diff);
        if (w_abs_diff <= c_STEP17) begin
            w_step_val = w_goal;
        end else if (w_diff[16]) begin
            w_step_val = cmd_out_q - c_STEP16;
        end else begin
            w_step_val = cmd_out_q + c_STEP16;
        end
    end

    // A state transition takes the edge; the ramp only moves on edges that stay put.
    always_comb begin
        state_d   = state_q;
        cmd_out_d = cmd_out_q;
        target_d  = target_q;
        dead_d    = '0;
        presc_d   = w_tick ? '0 : presc_q + 1'b1;

        if (bus.cmd_valid && (state_q != ST_FAULT)) begin
            target_d = w_cmd_in_clamped;
        end

        if (bus.estop) begin
            state_d   = ST_FAULT;
            cmd_out_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_out_d = '0;
                    if (bus.enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_rev || !bus.enable) begin
                        state_d = ST_BRAKE;
                    end else if (w_tick) begin
                        cmd_out_d = w_step_val;
                    end
                end
                ST_BRAKE: begin
                    if (cmd_out_q == '0) begin
                        state_d = bus.enable ? ST_DEAD : ST_IDLE;
                    end else if (w_tick) begin
                        cmd_out_d = w_step_val;
                    end
                end
                ST_DEAD: begin
                    cmd_out_d = '0;
                    if (dead_q == c_DEAD_LAST) begin
                        state_d = bus.enable ? ST_RUN : ST_IDLE;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    cmd_out_d = '0;
                    if (!bus.enable) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cmd_out_d = '0;
                end
            endcase
        end

        at_target_d = (state_d == ST_RUN) && (cmd_out_d == target_d);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_out_q   <= '0;
            target_q    <= '0;
            presc_q     <= '0;
            dead_q      <= '0;
            at_target_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_out_q   <= cmd_out_d;
            target_q    <= target_d;
            presc_q     <= presc_d;
            dead_q      <= dead_d;
            at_target_q <= at_target_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.cmd_out   = cmd_out_q;
    assign bus.state     = state_q;
    assign bus.at_target = at_target_q;
    assign bus.fault     = fault_q;

endmodule
`default_nettype wire

// File: doc/motor_cmd_sequencer.md
MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 16: maximum |change| of cmd_out per ramp tick.
REQ-002 SHALL have parameter TICK_DIV, default 256: clk cycles per ramp tick (>=1).
REQ-003 SHALL have parameter DEAD_CYCLES, default 1000: clk cycles held at zero during a direction reversal (>=1).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  level; 1 = run the motor, 0 = ramp down and idle.
REQ-007 estop  input  1  level; emergency stop, highest priority.
REQ-008 cmd_in  input  16  signed target command, sampled only when cmd_valid=1.
REQ-009 cmd_valid  input  1  single-cycle strobe loading cmd_in into the target register.
REQ-010 cmd_out  output  16  signed, registered command driving the PWM stage's pid_output.
REQ-011 state  output  3  current state: IDLE=0, RUN=1, BRAKE=2, DEAD=3, FAULT=4.
REQ-012 at_target  output  1  1 when state=RUN and cmd_out equals the target.
REQ-013 fault  output  1  1 while state=FAULT.

Function
REQ-014 Target register SHALL load on cmd_valid in any state except FAULT; cmd_in=-32768 SHALL be clamped to -32767.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 freely, asserting an internal tick when at TICK_DIV-1, then wrapping to 0.
REQ-016 A ramp step SHALL occur only on tick: if |goal-cmd_out| <= RAMP_STEP, cmd_out <= goal; otherwise cmd_out moves RAMP_STEP toward goal; 17-bit difference arithmetic, no overshoot, no wrap.
REQ-017 Reversal condition rev SHALL be (cmd_out>0 and target<0) or (cmd_out<0 and target>0); zero is neither sign.
REQ-018 IDLE: cmd_out held 0; enable=1 -> RUN next cycle.
REQ-019 RUN: goal=target; rev=1 -> BRAKE; enable=0 -> BRAKE; otherwise stay.
REQ-020 BRAKE: goal=0; on the cycle cmd_out equals 0: enable=0 -> IDLE, else -> DEAD with dead counter cleared.
REQ-021 DEAD: cmd_out held 0; dead counter increments every clk; after DEAD_CYCLES cycles in DEAD -> RUN if enable=1, else IDLE.
REQ-022 estop=1 in any state SHALL force, on the next edge, cmd_out=0, state=FAULT, regardless of tick or cmd_valid.
REQ-023 FAULT: cmd_out held 0; exit to IDLE only when estop=0 and enable=0 in the same cycle.
REQ-024 Priority on a single edge: reset > estop > enable/rev transitions > ramp step; cmd_valid and a state transition in the same cycle SHALL both take effect.
REQ-025 Entering RUN from DEAD SHALL not require a tick; first ramp step occurs at the next tick.
REQ-026 Target change mid-BRAKE that removes the reversal SHALL NOT abort BRAKE; sequence completes through DEAD.

Reset
REQ-027 On reset: cmd_out=0, target=0, state=IDLE, at_target=0, fault=0, prescaler=0, dead counter=0.
REQ-028 Reset asserted mid-ramp or mid-DEAD SHALL produce the REQ-027 values on the next edge, no partial step.

Verification (TICK_DIV=4, RAMP_STEP=100, DEAD_CYCLES=8)
REQ-029 Ramp up: enable=1, cmd_in=250 -> cmd_out 100, 200, 250 on three consecutive ticks (4 clks apart); at_target=1 after 250.
REQ-030 Reversal: from cmd_out=250 load cmd_in=-150 -> BRAKE: 150, 50, 0; DEAD held 8 clks; RUN: -100, -150.
REQ-031 Disable: cmd_out=120, enable=0 -> 20, 0, then IDLE with no DEAD phase.
REQ-032 E-stop: estop pulse mid-ramp at cmd_out=200 -> next edge cmd_out=0, fault=1; stays FAULT while enable=1 after estop drops; enable=0 -> IDLE.
REQ-033 Clamp: cmd_in=-32768 -> target -32767; cmd_out never exceeds |32767| or wraps.
REQ-034 Reset mid-DEAD -> next cycle state=IDLE, cmd_out=0; enable=1 restarts cleanly from 0.
